// File: rtl/engine_csr_bank_if.sv
// Software register-access bus for engine_csr_bank.
// One write port and one read port; read data returns registered, one cycle after rd_en.
interface engine_csr_bank_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 256
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/engine_csr_bank.sv
// engine_csr_bank: per-channel data register + CSR for NUM_CH crypto engines.
// Address map {channel, sel}: sel 0 = data register, sel 1 = CSR.
// CSR: [0] START/BUSY, [1] DONE (W1C), [2] ERR (W1C), [3] IE, [CSR_W-1:4] MODE.
// Optional busy watchdog: define TIMEOUT_EN to enable a TIMEOUT_CYC cycle limit
// in BUSY; without it a channel waits for its engine indefinitely.
module engine_csr_bank #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 256,
  parameter int CSR_W       = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clock,
  input  logic                        reset_n,
  engine_csr_bank_if.slave            bus,
  output logic [NUM_CH*DATA_W-1:0]    eng_data,
  output logic [NUM_CH*(CSR_W-4)-1:0] eng_mode,
  output logic [NUM_CH-1:0]           eng_start,
  input  logic [NUM_CH-1:0]           eng_done,
  input  logic [NUM_CH-1:0]           eng_err,
  output logic                        irq
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ADDR_W = CH_W + 1;
  localparam int MODE_W = CSR_W - 4;

  // Reject configurations the address map and CSR layout cannot represent.
  if (NUM_CH < 1 || NUM_CH > 8 || CSR_W < 4 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("engine_csr_bank: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t            state_q [NUM_CH];
  logic [DATA_W-1:0] data_q  [NUM_CH];
  logic [MODE_W-1:0] mode_q  [NUM_CH];
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] err_q;
  logic [NUM_CH-1:0] ie_q;

  // Address decode.
  logic [CH_W-1:0]  wr_ch;
  logic [CH_W-1:0]  rd_ch;
  logic             wr_sel;
  logic             rd_sel;
  logic [CSR_W-1:0] wr_csr;

  assign wr_ch  = bus.wr_addr[ADDR_W-1:1];
  assign wr_sel = bus.wr_addr[0];
  assign rd_ch  = bus.rd_addr[ADDR_W-1:1];
  assign rd_sel = bus.rd_addr[0];
  assign wr_csr = bus.wr_data[CSR_W-1:0];

  // Per-channel events for this cycle.
  logic [NUM_CH-1:0] csr_we;
  logic [NUM_CH-1:0] data_we;
  logic [NUM_CH-1:0] launch;
  logic [NUM_CH-1:0] overrun;
  logic [NUM_CH-1:0] sw_csr;
  logic [NUM_CH-1:0] hw_done;
  logic [NUM_CH-1:0] hw_err;
  logic [NUM_CH-1:0] timeout;
  logic [NUM_CH-1:0] finish;

`ifdef TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  // Watchdog fires on the TIMEOUT_CYC-th BUSY cycle unless the engine answers in that cycle.
  always_comb begin
    timeout = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      timeout[c] = (state_q[c] == ST_BUSY) & ~eng_done[c] & ~eng_err[c] &
                   (cnt_q[c] == CNT_W'(TIMEOUT_CYC - 1));
    end
  end
`else
  assign timeout = '0;
`endif

  // Decode software writes and engine responses into per-channel events.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    csr_we  = '0;
    data_we = '0;
    launch  = '0;
    overrun = '0;
    sw_csr  = '0;
    hw_done = '0;
    hw_err  = '0;
    finish  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.wr_en && wr_ch == CH_W'(c)) begin
        csr_we[c]  = wr_sel;
        data_we[c] = ~wr_sel;
      end
      launch[c]  = csr_we[c] & wr_csr[0] & (state_q[c] == ST_IDLE);
      overrun[c] = csr_we[c] & wr_csr[0] & (state_q[c] != ST_IDLE);
      sw_csr[c]  = csr_we[c] & ~wr_csr[0];
      hw_done[c] = (state_q[c] == ST_BUSY) & eng_done[c];
      hw_err[c]  = (state_q[c] == ST_BUSY) & eng_err[c];
      finish[c]  = hw_done[c] | hw_err[c] | timeout[c];
    end
  end

  // Channel sequencers: IDLE -> START (one-cycle eng_start) -> BUSY -> IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
`ifdef TIMEOUT_EN
        cnt_q[c]   <= '0;
`endif
      end
      eng_start <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // NOTE: state is updated with <= so every channel sees the pre-edge values of its neighbours and itself.
        case (state_q[c])
          ST_IDLE: begin
            if (launch[c]) begin
              state_q[c]   <= ST_START;
              eng_start[c] <= 1'b1;
            end
          end
          ST_START: begin
            state_q[c]   <= ST_BUSY;
            eng_start[c] <= 1'b0;
`ifdef TIMEOUT_EN
            cnt_q[c]     <= '0;
`endif
          end
          ST_BUSY: begin
            if (finish[c]) begin
              state_q[c] <= ST_IDLE;
            end
`ifdef TIMEOUT_EN
            else begin
              cnt_q[c] <= cnt_q[c] + CNT_W'(1);
            end
`endif
          end
          default: begin
            state_q[c]   <= ST_IDLE;
            eng_start[c] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Data registers, sticky flags, IE and MODE; hardware sets win over W1C.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        // NOTE: the data array is reset because engines may consume eng_data right after reset.
        data_q[c] <= '0;
        mode_q[c] <= '0;
      end
      done_q <= '0;
      err_q  <= '0;
      ie_q   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (data_we[c] && state_q[c] == ST_IDLE) begin
          data_q[c] <= bus.wr_data;
        end
        if (launch[c] || sw_csr[c]) begin
          ie_q[c]   <= wr_csr[3];
          mode_q[c] <= wr_csr[CSR_W-1:4];
        end
        done_q[c] <= hw_done[c] |
                     (done_q[c] & ~(launch[c] | (sw_csr[c] & wr_csr[1])));
        err_q[c]  <= hw_err[c] | timeout[c] | overrun[c] |
                     (err_q[c] & ~((launch[c] | sw_csr[c]) & wr_csr[2]));
      end
    end
  end

  // Software view of each CSR and the combinational read mux.
  logic [CSR_W-1:0]  csr_view [NUM_CH];
  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      csr_view[c] = {mode_q[c], ie_q[c], err_q[c], done_q[c], state_q[c] != ST_IDLE};
      if (rd_ch == CH_W'(c)) begin
        rd_mux = rd_sel ? DATA_W'(csr_view[c]) : data_q[c];
      end
    end
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data <= rd_mux;
      end
    end
  end

  // Interrupt: registered OR of enabled sticky flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(ie_q & (done_q | err_q));
    end
  end

  // Flatten per-channel registers onto the engine-facing buses.
  always_comb begin
    eng_data = '0;
    eng_mode = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      eng_data[c*DATA_W +: DATA_W] = data_q[c];
      eng_mode[c*MODE_W +: MODE_W] = mode_q[c];
    end
  end
endmodule

// File: doc/engine_csr_bank.md
Name: engine_csr_bank

Overview:
Parametrised register bank with a control/status register (CSR) per channel, serving NUM_CH crypto engines (AES, SHA2, PRNG, ...).
- Replaces ad-hoc per-engine data registers, CSRs and the read mux.
- Provides an addressed software write/read port, a one-cycle start handshake to each engine, and sticky W1C done/error flags.
- Per-channel sequencing FSM, data-register lock while busy, and a registered interrupt.

Parameters:
NUM_CH, 4, number of engine channels (1..8)
DATA_W, 256, width of each channel data register and of the bus
CSR_W, 8, CSR width (>=4); bits [CSR_W-1:4] are the mode field
TIMEOUT_CYC, 1024, busy watchdog limit; used only with TIMEOUT_EN
(local) CH_W = max(1, clog2(NUM_CH)); ADDR_W = CH_W+1

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  software write strobe
wr_addr  in  ADDR_W  {channel, sel}; sel 0 = data register, sel 1 = CSR
wr_data  in  DATA_W  write data; CSR uses [CSR_W-1:0]
rd_en  in  1  software read strobe
rd_addr  in  ADDR_W  read address, same map as wr_addr
rd_data  out  DATA_W  registered read data
rd_valid  out  1  high one cycle after rd_en
eng_data  out  NUM_CH*DATA_W  data registers, channel c at [c*DATA_W +: DATA_W]
eng_mode  out  NUM_CH*(CSR_W-4)  mode fields
eng_start  out  NUM_CH  one-cycle start pulse per channel
eng_done  in  NUM_CH  engine completion pulse
eng_err  in  NUM_CH  engine error pulse
irq  out  1  registered interrupt

Behaviour:
- Reset (async, reset_n=0): all data registers, CSRs, FSMs, rd_data, rd_valid, eng_start and irq go to 0; all channels enter IDLE.
- CSR bit map:
  - bit0 START/BUSY: write 1 requests start; reads 1 while the FSM is in START or BUSY.
  - bit1 DONE: sticky, W1C.
  - bit2 ERR: sticky, W1C.
  - bit3 IE: read/write.
  - [CSR_W-1:4] MODE: read/write, drives eng_mode.
- CSR write, bit0=0: bits 1/2 are W1C, bit3 and MODE are written. Write-0 to DONE or ERR has no effect.
- Channel FSM:
  - IDLE -> START on a CSR write with bit0=1. In the same cycle DONE is cleared, and IE/MODE are written from the same data.
  - START: eng_start[c]=1 for exactly one cycle, then -> BUSY.
  - BUSY: wait for eng_done[c]. On eng_done -> IDLE and set DONE. On eng_err -> IDLE and set ERR. If both arrive together, both flags are set.
- START write while in START/BUSY: ignored, ERR set (overrun); MODE/IE are not updated.
- eng_done/eng_err while in IDLE: ignored; no flag changes.
- Data register write while the channel is in START/BUSY: dropped (locked). In IDLE the register updates at the next edge.
- Simultaneous hardware set and software W1C on the same flag: the set wins.
- Read:
  - rd_data and rd_valid are valid the cycle after rd_en.
  - CSR reads are zero-extended to DATA_W.
  - Addresses with channel >= NUM_CH read 0 and their writes are ignored.
  - Read-after-write to the same address in the same cycle returns the old value.
- irq registered: OR over c of IE[c] & (DONE[c] | ERR[c]). irq follows its condition with one cycle of latency.

Optional Feature:
TIMEOUT_EN
- Defined: each channel has a counter, clog2(TIMEOUT_CYC+1) bits, cleared on entering BUSY and incremented each BUSY cycle. If it reaches TIMEOUT_CYC without eng_done/eng_err, the FSM goes to IDLE and sets ERR. eng_done in the same cycle as the timeout takes priority and sets DONE only.
- Undefined: no counter; BUSY waits indefinitely.

Test Plan (NUM_CH=4, DATA_W=256, CSR_W=8):
1. Reset, then read every address 0..7 -> rd_data=0, rd_valid=1 one cycle after each rd_en; irq=0.
2. Write addr 2 (ch1 data)=256'hA5..A5; write addr 3=8'h39 (START, IE, MODE=3) -> eng_start[1] pulses once, eng_mode ch1=4'h3. Read addr 3 -> 8'h39 with bit1=0. Pulse eng_done[1] -> CSR reads 8'h3A, irq=1 the next cycle.
3. Continuing from 2: write addr 3 = 8'h3A (W1C DONE) -> CSR 8'h38, irq drops to 0; same-cycle eng_done ignored (channel is IDLE).
4. Ch0 busy: write addr 0 = 256'h1234 -> data register unchanged. Write addr 1 = 8'h01 -> ERR set, CSR reads 8'h05, no second eng_start.
5. Ch2 busy with ERR=1: in one cycle pulse eng_err[2] and write 8'h04 to addr 5 -> ERR remains 1.
6. TIMEOUT_EN with TIMEOUT_CYC=16: start ch3 with no eng_done -> after 16 BUSY cycles CSR bit0=0, ERR=1. A repeat run with eng_done on cycle 16 -> DONE=1, ERR=0.
